// File: rtl/alu16_arbiter.sv
// Two-requester round-robin front end for a single shared combinational alu16.
// One operation in flight; results are held in a registered response slot until consumed.
module alu16_arbiter #(
   parameter int MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [15:0] r0_a,
   input  logic [15:0] r0_b,
   input  logic [2:0]  r0_op,
   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [15:0] r1_a,
   input  logic [15:0] r1_b,
   input  logic [2:0]  r1_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [15:0] alu_y,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [15:0] rsp_y,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam logic [2:0] OP_MUL   = 3'b111;
   localparam logic [2:0] MUL_LOAD = 3'(MUL_CYCLES - 1);

   state_t      state_r;
   state_t      state_s;
   logic        gnt0_s;
   logic        gnt1_s;
   logic        grant_s;
   logic        exec_done_s;
   logic        rsp_take_s;
   logic [2:0]  load_cnt_s;
   logic [15:0] sel_a_s;
   logic [15:0] sel_b_s;
   logic [2:0]  sel_op_s;

   logic [15:0] a_r;
   logic [15:0] b_r;
   logic [2:0]  op_r;
   logic        id_r;
   logic        last_r;
   logic [2:0]  cnt_r;
   logic        rsp_valid_r;
   logic        rsp_id_r;
   logic [15:0] rsp_y_r;
   logic        busy_r;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, round-robin grant and EXEC/RESP handshakes.
   always_comb begin
      state_s     = state_r;
      gnt0_s      = 1'b0;
      gnt1_s      = 1'b0;
      exec_done_s = 1'b0;
      rsp_take_s  = 1'b0;
      case (state_r)
         IDLE: begin
            // last_r == 1 means r1 went last, so r0 wins a tie.
            gnt0_s = r0_valid & (~r1_valid | last_r);
            gnt1_s = r1_valid & ~gnt0_s;
            if (gnt0_s | gnt1_s) begin
               state_s = EXEC;
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: begin
            if (cnt_r == 3'd0) begin
               exec_done_s = 1'b1;
               state_s     = RESP;
            end else begin
               state_s = EXEC;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_take_s = 1'b1;
               state_s    = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Operand mux for the granted requester and its EXEC length.
   always_comb begin
      grant_s = gnt0_s | gnt1_s;
      if (gnt1_s) begin
         sel_a_s  = r1_a;
         sel_b_s  = r1_b;
         sel_op_s = r1_op;
      end else begin
         sel_a_s  = r0_a;
         sel_b_s  = r0_b;
         sel_op_s = r0_op;
      end
      if (sel_op_s == OP_MUL) begin
         load_cnt_s = MUL_LOAD;
      end else begin
         load_cnt_s = 3'd0;
      end
   end

   // Capture registers, EXEC down-counter and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r    <= 16'h0000;
         b_r    <= 16'h0000;
         op_r   <= 3'b000;
         id_r   <= 1'b0;
         last_r <= 1'b1;
         cnt_r  <= 3'd0;
      end else if (grant_s) begin
         a_r    <= sel_a_s;
         b_r    <= sel_b_s;
         op_r   <= sel_op_s;
         id_r   <= gnt1_s;
         last_r <= gnt1_s;
         cnt_r  <= load_cnt_s;
      end else if ((state_r == EXEC) && (cnt_r != 3'd0)) begin
         cnt_r <= cnt_r - 3'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Response slot and busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= 1'b0;
         rsp_y_r     <= 16'h0000;
         busy_r      <= 1'b0;
      end else begin
         busy_r <= (state_s != IDLE);
         if (exec_done_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_y_r     <= alu_y;
         end else if (rsp_take_s) begin
            rsp_valid_r <= 1'b0;
         end else begin
            rsp_valid_r <= rsp_valid_r;
         end
      end
   end

   // Ready is the only combinational output; it is masked while reset is asserted.
   assign r0_ready  = gnt0_s & ~rst;
   assign r1_ready  = gnt1_s & ~rst;
   assign alu_a     = a_r;
   assign alu_b     = b_r;
   assign alu_op    = op_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_id    = rsp_id_r;
   assign rsp_y     = rsp_y_r;
   assign busy      = busy_r;

endmodule
